// File: rtl/slice_add_sequencer_pkg.sv
// Shared types and constants for the two-requester sliced adder sequencer.
// Also holds the single-bit full-adder cell used by the slice adder.
package slice_add_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SLICE = 4;
    localparam int ID_W          = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Returns {carry_out, sum} of a single full-adder cell.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/slice_csel_adder.sv
// SLICE-bit carry-select adder: two full-adder ripple chains, one assuming
// carry-in 0 and one assuming carry-in 1, with the real carry-in picking the result.
module slice_csel_adder
    import slice_add_sequencer_pkg::*;
#(
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE:0]   c0_s;
    logic [SLICE:0]   c1_s;
    logic [SLICE-1:0] s0_s;
    logic [SLICE-1:0] s1_s;

    // Both speculative ripple chains
    always_comb begin
        c0_s    = '0;
        c1_s    = '0;
        s0_s    = '0;
        s1_s    = '0;
        c0_s[0] = 1'b0;
        c1_s[0] = 1'b1;
        for (int i = 0; i < SLICE; i++) begin
            {c0_s[i+1], s0_s[i]} = full_add(a[i], b[i], c0_s[i]);
            {c1_s[i+1], s1_s[i]} = full_add(a[i], b[i], c1_s[i]);
        end
    end

    // Carry-in selects the precomputed chain
    always_comb begin
        if (cin) begin
            sum  = s1_s;
            cout = c1_s[SLICE];
        end else begin
            sum  = s0_s;
            cout = c0_s[SLICE];
        end
    end

endmodule

// File: rtl/slice_add_sequencer.sv
// Round-robin arbitrated multi-cycle adder: accepts one operation from two
// requesters, adds it SLICE bits per cycle, and holds the result until taken.
module slice_add_sequencer
    import slice_add_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic [ID_W-1:0]  res_id
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int K_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NSLICE - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              carry_q, carry_d, cout_q, cout_d;
    logic [ID_W-1:0]   id_q, id_d, last_q, last_d;
    logic [K_W-1:0]    k_q, k_d;

    logic              gnt0_s, gnt1_s;
    logic [SLICE-1:0]  slice_a_s, slice_b_s, slice_sum_s;
    logic              slice_cout_s;

    // Round-robin grant; last_q holds the requester served most recently
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if ((state_q == ST_IDLE) && !rst) begin
            if (req0_valid && req1_valid) begin
                if (last_q == ID_W'(1)) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                end
            end else if (req0_valid) begin
                gnt0_s = 1'b1;
            end else if (req1_valid) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;

    assign slice_a_s = a_q[k_q*SLICE +: SLICE];
    assign slice_b_s = b_q[k_q*SLICE +: SLICE];

    slice_csel_adder #(.SLICE(SLICE)) u_adder (
        .a    (slice_a_s),
        .b    (slice_b_s),
        .cin  (carry_q),
        .sum  (slice_sum_s),
        .cout (slice_cout_s)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        id_d    = id_q;
        last_d  = last_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt0_s) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    carry_d = req0_cin;
                    id_d    = ID_W'(0);
                    last_d  = ID_W'(0);
                    k_d     = '0;
                    state_d = ST_RUN;
                end else if (gnt1_s) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    carry_d = req1_cin;
                    id_d    = ID_W'(1);
                    last_d  = ID_W'(1);
                    k_d     = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d[k_q*SLICE +: SLICE] = slice_sum_s;
                carry_d = slice_cout_s;
                if (k_q == K_LAST) begin
                    cout_d  = slice_cout_s;
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + K_W'(1);
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset points the arbiter at req0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= '0;
            last_q  <= ID_W'(1);
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            last_q  <= last_d;
            k_q     <= k_d;
        end
    end

    assign res_valid = (state_q == ST_DONE);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;

endmodule

// File: tb/tb_slice_add_sequencer.sv
// Self-checking bench: directed scenarios plus randomized operations compared
// against a behavioural model (whole-word addition, round-robin by last served).
module tb_slice_add_sequencer;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int NSL   = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_cin, req1_cin;
    logic             res_valid, res_ready, res_cout;
    logic [WIDTH-1:0] res_sum;
    logic [0:0]       res_id;

    int vectors = 0;
    int errors  = 0;

    slice_add_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    endfunction

    task automatic randomize_operands;
        req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_cin = 1'($urandom);
        req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_cin = 1'($urandom);
    endtask

    task automatic do_reset;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        randomize_operands();
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
        randomize_operands();
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        tick();
        vectors++;
        if ({res_valid, res_sum, res_cout, res_id} !== {1'b0, {WIDTH{1'b0}}, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_outputs: got v=%b s=%h c=%b id=%b want all 0", res_valid, res_sum, res_cout, res_id);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL reset_first_grant: got %b want 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_req0_carry;
        do_reset();
        req0_a = 16'hFFFF; req0_b = 16'h0001; req0_cin = 1'b0; req0_valid = 1'b1;
        #1;
        vectors++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL req0_grant: got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        randomize_operands();
        for (int n = 0; n < NSL; n++) begin
            vectors++;
            if (res_valid !== 1'b0) begin
                errors++; $display("FAIL req0_latency: res_valid %b at run cycle %0d want 0", res_valid, n);
            end
            tick();
        end
        vectors++;
        if ({res_valid, res_sum, res_cout, res_id} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL req0_result: got v=%b s=%h c=%b id=%b want 1 0000 1 0", res_valid, res_sum, res_cout, res_id);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vectors++;
        if ({res_valid, res_sum} !== {1'b0, 16'h0000}) begin
            errors++; $display("FAIL req0_release: got v=%b s=%h want 0 0000", res_valid, res_sum);
        end
    endtask

    task automatic test_req1_cin;
        do_reset();
        req1_a = 16'h1234; req1_b = 16'h4321; req1_cin = 1'b1; req1_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++; $display("FAIL req1_grant: got %b want 01", {req0_ready, req1_ready});
        end
        tick();
        req1_valid = 1'b0;
        randomize_operands();
        repeat (NSL) tick();
        vectors++;
        if ({res_valid, res_sum, res_cout, res_id} !== {1'b1, 16'h5556, 1'b0, 1'b1}) begin
            errors++; $display("FAIL req1_result: got v=%b s=%h c=%b id=%b want 1 5556 0 1", res_valid, res_sum, res_cout, res_id);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vectors++;
        if ({res_valid, res_sum} !== {1'b0, 16'h5556}) begin
            errors++; $display("FAIL req1_hold_idle: got v=%b s=%h want 0 5556", res_valid, res_sum);
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH+1:0] q[$];
        logic [WIDTH+1:0] e;
        int accepts = 0;
        int last_c  = 0;
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            randomize_operands();
            #1;
            if (req0_ready || req1_ready) begin
                vectors++;
                if ({req0_ready, req1_ready} !== ((accepts % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL alt_grant: accept %0d got %b", accepts, {req0_ready, req1_ready});
                end
                if (accepts > 0) begin
                    vectors++;
                    if (c - last_c != 6) begin
                        errors++; $display("FAIL alt_period: got %0d cycles want 6", c - last_c);
                    end
                end
                if (req1_ready) q.push_back({1'b1, ref_add(req1_a, req1_b, req1_cin)});
                else            q.push_back({1'b0, ref_add(req0_a, req0_b, req0_cin)});
                last_c = c;
                accepts++;
            end
            if (res_valid) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                vectors++;
                if ({res_id, res_cout, res_sum} !== e) begin
                    errors++; $display("FAIL alt_result: got id=%b c=%b s=%h want %h", res_id, res_cout, res_sum, e);
                end
            end
            tick();
        end
        vectors++;
        if (accepts != 4) begin
            errors++; $display("FAIL alt_count: got %0d accepts want 4", accepts);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    endtask

    task automatic test_stall;
        logic [WIDTH:0] e;
        do_reset();
        randomize_operands();
        e = ref_add(req0_a, req0_b, req0_cin);
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
        tick();
        randomize_operands();
        repeat (NSL) tick();
        for (int n = 0; n < 4; n++) begin
            randomize_operands();
            #1;
            vectors++;
            if ({res_valid, res_id, res_cout, res_sum, req0_ready, req1_ready} !== {1'b1, 1'b0, e, 2'b00}) begin
                errors++; $display("FAIL stall_hold: cycle %0d got v=%b id=%b c=%b s=%h rdy=%b%b want 1 0 %h 00",
                                   n, res_valid, res_id, res_cout, res_sum, req0_ready, req1_ready, e);
            end
            if (n == 3) res_ready = 1'b1;
            #1;
            if (n == 3) begin
                vectors++;
                if ({req0_ready, req1_ready} !== 2'b00) begin
                    errors++; $display("FAIL stall_no_grant_on_release: got %b want 00", {req0_ready, req1_ready});
                end
            end
            tick();
        end
        res_ready = 1'b0;
        vectors++;
        if ({res_valid, req0_ready, req1_ready} !== 3'b001) begin
            errors++; $display("FAIL stall_next_grant: got v=%b rdy=%b%b want 0 01", res_valid, req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_abort;
        logic [WIDTH:0] e;
        do_reset();
        randomize_operands();
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        e = ref_add(req1_a, req1_b, req1_cin);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if ({res_valid, res_sum, res_cout, res_id, req0_ready, req1_ready} !== {1'b0, {WIDTH{1'b0}}, 1'b0, 1'b0, 2'b01}) begin
            errors++; $display("FAIL abort_state: got v=%b s=%h c=%b id=%b rdy=%b%b want 0 0000 0 0 01",
                               res_valid, res_sum, res_cout, res_id, req0_ready, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        randomize_operands();
        repeat (NSL) tick();
        vectors++;
        if ({res_valid, res_id, res_cout, res_sum} !== {1'b1, 1'b1, e}) begin
            errors++; $display("FAIL abort_followup: got v=%b id=%b c=%b s=%h want 1 1 %h", res_valid, res_id, res_cout, res_sum, e);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [WIDTH:0] e;
        logic           exp_id;
        logic           last;
        logic [1:0]     exp_rdy;
        logic           v0, v1, done;
        do_reset();
        last = 1'b1;
        for (int op = 0; op < 10000; op++) begin
            done = 1'b0;
            for (int w = 0; w < 100 && !done; w++) begin
                v0 = ($urandom_range(0, 2) != 0);
                v1 = ($urandom_range(0, 2) != 0);
                req0_valid = v0; req1_valid = v1; res_ready = 1'($urandom);
                randomize_operands();
                #1;
                if (v0 && v1) exp_rdy = last ? 2'b10 : 2'b01;
                else          exp_rdy = {v0, v1};
                vectors++;
                if ({res_valid, req0_ready, req1_ready} !== {1'b0, exp_rdy}) begin
                    errors++; $display("FAIL rand_grant: op %0d got v=%b rdy=%b%b want 0 %b", op, res_valid, req0_ready, req1_ready, exp_rdy);
                end
                if (v0 || v1) begin
                    exp_id = exp_rdy[0];
                    e = exp_id ? ref_add(req1_a, req1_b, req1_cin) : ref_add(req0_a, req0_b, req0_cin);
                    last = exp_id;
                    done = 1'b1;
                end
                tick();
            end
            for (int n = 0; n < NSL; n++) begin
                req0_valid = 1'($urandom); req1_valid = 1'($urandom); res_ready = 1'($urandom);
                randomize_operands();
                #1;
                vectors++;
                if ({res_valid, req0_ready, req1_ready} !== 3'b000) begin
                    errors++; $display("FAIL rand_run: op %0d cycle %0d got v=%b rdy=%b%b want 000", op, n, res_valid, req0_ready, req1_ready);
                end
                tick();
            end
            done = 1'b0;
            for (int w = 0; w < 50 && !done; w++) begin
                req0_valid = 1'($urandom); req1_valid = 1'($urandom);
                res_ready = ($urandom_range(0, 7) != 0);
                randomize_operands();
                #1;
                vectors++;
                if ({res_valid, res_id, res_cout, res_sum, req0_ready, req1_ready} !== {1'b1, exp_id, e, 2'b00}) begin
                    errors++; $display("FAIL rand_result: op %0d got v=%b id=%b c=%b s=%h rdy=%b%b want 1 %b %h 00",
                                       op, res_valid, res_id, res_cout, res_sum, req0_ready, req1_ready, exp_id, e);
                end
                done = res_ready;
                tick();
            end
            if (!done) begin
                vectors++; errors++;
                $display("FAIL rand_timeout: op %0d result never released", op);
                res_ready = 1'b1;
                tick();
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        randomize_operands();
        tick();
        test_reset();
        test_req0_carry();
        test_req1_cin();
        test_back_to_back();
        test_stall();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/slice_add_sequencer.md
SLICE_ADD_SEQUENCER -- requirements
Module: slice_add_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter SLICE, default 4: bits added per cycle; WIDTH is an integer multiple of SLICE.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each: requester n presents an operation.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1 each: requester n's operation is accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, WIDTH each: operands.
REQ-008 SHALL have ports req0_cin / req1_cin, input, 1 each: carry-in.
REQ-009 SHALL have port res_valid, output, 1: result available.
REQ-010 SHALL have port res_ready, input, 1: consumer takes the result.
REQ-011 SHALL have port res_sum, output, WIDTH: a+b+cin modulo 2^WIDTH.
REQ-012 SHALL have port res_cout, output, 1: carry out of the MSB.
REQ-013 SHALL have port res_id, output, 1: index of the requester that owns the result.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 In IDLE, SHALL grant one valid requester; the grant SHALL be combinational from valid and the round-robin pointer.
REQ-016 When both requesters are valid, SHALL grant the one not served last; a sole requester SHALL always win.
REQ-017 reqN_ready SHALL be high only in IDLE and only for the granted requester.
REQ-018 On accept (valid && ready), SHALL latch a, b, cin and id, clear the slice index to 0, update the pointer, and go to RUN.
REQ-019 In RUN, each cycle SHALL add operand slice k (bits k*SLICE+SLICE-1 .. k*SLICE) with the carry register.
REQ-020 In RUN, the carry register SHALL initially hold the latched cin.
REQ-021 In RUN, SHALL write the slice sum into result bits k, store the slice carry, and increment k.
REQ-022 After slice WIDTH/SLICE-1, SHALL go to DONE with res_sum and res_cout final.
REQ-023 Latency: accept in cycle T gives res_valid high from cycle T+1+WIDTH/SLICE (T+5 at defaults).
REQ-024 In DONE, res_valid SHALL be high, and res_sum, res_cout and res_id SHALL be stable until res_ready.
REQ-025 On res_valid && res_ready, SHALL go to IDLE and drop res_valid the next cycle; no new grant SHALL occur in that cycle.
REQ-026 Requester valid SHALL be ignored outside IDLE.
REQ-027 Requester operands SHALL NOT be sampled after accept.
REQ-028 res_sum SHALL hold its last value in IDLE.
REQ-029 All-ones + all-ones + 1 SHALL give sum all-ones, cout 1, with no overflow of internal widths.

Reset
REQ-030 rst high at a clock edge SHALL force IDLE, and SHALL set res_valid 0, res_sum 0, res_cout 0, res_id 0, carry 0 and k 0.
REQ-031 rst high at a clock edge SHALL set the pointer so that req0 wins the first simultaneous request.
REQ-032 While rst is high, req0_ready and req1_ready SHALL be 0.
REQ-033 Reset in RUN or DONE SHALL abort the operation without emitting a result.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, default WIDTH/SLICE constants, and the requester-id width.
REQ-035 The per-cycle adder SHALL be one sub-module, slice_csel_adder: a SLICE-bit carry-select adder of full-adder cells with a cin-driven mux.
REQ-036 The sequencer SHALL instantiate exactly one slice_csel_adder.

Verification
REQ-037 Scenario: req0 0xFFFF+0x0001 cin 0 -> res_sum 0x0000, res_cout 1, res_id 0, res_valid 5 cycles after accept.
REQ-038 Scenario: req1 0x1234+0x4321 cin 1 -> res_sum 0x5556, res_cout 0, res_id 1.
REQ-039 Scenario: both valid continuously after reset, res_ready 1 -> grants alternate 0,1,0,1; one result per 6 cycles.
REQ-040 Scenario: res_ready low 3 cycles in DONE -> outputs unchanged; both readies 0 throughout.
REQ-041 Scenario: rst asserted in the 2nd RUN cycle -> next cycle IDLE, all outputs 0; a held req1_valid is then granted.
REQ-042 Scenario: 10k random operands and cin on both ports, random res_ready -> every result equals the reference a+b+cin and res_id matches the owning requester.
